// File: rtl/key8_encoder.sv
// key8_encoder: debounced 8-key priority encoder.
//
// Eight active-low push-buttons are synchronised through two flops, debounced
// as a group by a small FSM, and encoded to the index of the lowest pressed
// key. The accepted code is held (with valid) until a debounced release.
// strobe pulses once per accepted press. multi flags a chord (more than one
// key down in the accepted pattern).
//
// Optional feature: define KEY8_ENC_REPEAT_EN to enable auto-repeat. While a
// key is held, strobe pulses every REPEAT_CYCLES clocks after the press strobe.
// Without the macro, no repeat counter exists and strobe fires once per press.
//
// All outputs are registered. The reset is synchronous and active-high.

module key8_encoder #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned REPEAT_CYCLES   = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] keys_n,
    output logic [2:0] code,
    output logic       valid,
    output logic       strobe,
    output logic       multi
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] ST_PRESSED  = 2'd2;
    localparam logic [1:0] ST_RELEASE  = 2'd3;

    // Terminal count of a debounce window. The counter starts at 0 on the
    // first sample, so DEBOUNCE_CYCLES further stable samples end the window.
    localparam logic [15:0] DEB_LAST = 16'(DEBOUNCE_CYCLES - 1);

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------

    // Index of the lowest set bit. Key 0 has the highest priority.
    function automatic logic [2:0] lowest_index(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

    // True when more than one bit is set: clearing the lowest set bit
    // leaves something behind.
    function automatic logic more_than_one(input logic [7:0] v);
        return (v & (v - 8'd1)) != 8'd0;
    endfunction

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic [7:0]  sync1_q, sync2_q;
    logic [7:0]  s;
    logic        s_any;

    logic [1:0]  state_q, state_d;
    logic [7:0]  cand_q, cand_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  code_q, code_d;
    logic        valid_q, valid_d;
    logic        multi_q, multi_d;
    logic        strobe_q, strobe_d;
    logic        press_fire;
    logic        repeat_fire;

    // ------------------------------------------------------------------
    // Synchroniser
    // ------------------------------------------------------------------

    // Two-flop synchroniser for the raw asynchronous buttons. It resets to
    // all-released so that no phantom press is seen after reset.
    // NOTE: clocked state uses non-blocking (<=) so every flop samples the
    // pre-edge value of its source; blocking here would collapse the chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 8'hFF;
            sync2_q <= 8'hFF;
        end else begin
            sync1_q <= keys_n;
            sync2_q <= sync1_q;
        end
    end

    // Active-high view of the synchronised keys.
    assign s     = ~sync2_q;
    assign s_any = (s != 8'd0);

    // ------------------------------------------------------------------
    // Debounce FSM: next-state logic
    // ------------------------------------------------------------------

    // Compute the next FSM state, candidate, counter and held outputs.
    // NOTE: every variable gets a default at the top of the block so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        cand_d     = cand_q;
        cnt_d      = cnt_q;
        code_d     = code_q;
        valid_d    = valid_q;
        multi_d    = multi_q;
        press_fire = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (s_any) begin
                    cand_d  = s;
                    cnt_d   = 16'd0;
                    state_d = ST_DEBOUNCE;
                end
            end

            ST_DEBOUNCE: begin
                if (!s_any) begin
                    // Everything released before the window closed.
                    state_d = ST_IDLE;
                end else if (s != cand_q) begin
                    // Pattern moved: restart the window on the new pattern.
                    cand_d = s;
                    cnt_d  = 16'd0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d    = ST_PRESSED;
                    code_d     = lowest_index(cand_q);
                    multi_d    = more_than_one(cand_q);
                    valid_d    = 1'b1;
                    press_fire = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            ST_PRESSED: begin
                // A changed nonzero pattern is deliberately ignored so that
                // rolling into a chord never produces a second press.
                if (!s_any) begin
                    cnt_d   = 16'd0;
                    state_d = ST_RELEASE;
                end
            end

            ST_RELEASE: begin
                if (s_any) begin
                    // Release bounce: fall back silently, code untouched.
                    state_d = ST_PRESSED;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                    multi_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Optional auto-repeat
    // ------------------------------------------------------------------
`ifdef KEY8_ENC_REPEAT_EN
    localparam logic [15:0] REP_LAST = 16'(REPEAT_CYCLES - 1);

    logic [15:0] rep_cnt_q, rep_cnt_d;

    // Count clocks spent holding a key in PRESSED. The counter is zero in
    // every other state, so each entry into PRESSED starts from zero and
    // nothing advances while a release is being debounced.
    always_comb begin
        rep_cnt_d   = 16'd0;
        repeat_fire = 1'b0;
        if (state_q == ST_PRESSED && s_any) begin
            if (rep_cnt_q == REP_LAST) begin
                repeat_fire = 1'b1;
            end else begin
                rep_cnt_d = rep_cnt_q + 16'd1;
            end
        end
    end

    // Repeat counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rep_cnt_q <= 16'd0;
        end else begin
            rep_cnt_q <= rep_cnt_d;
        end
    end
`else
    // No auto-repeat: strobe comes from accepted presses only.
    assign repeat_fire = 1'b0;
`endif

    assign strobe_d = press_fire | repeat_fire;

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------

    // Register FSM state, debounce bookkeeping and all outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cand_q   <= 8'd0;
            cnt_q    <= 16'd0;
            code_q   <= 3'd0;
            valid_q  <= 1'b0;
            multi_q  <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            code_q   <= code_d;
            valid_q  <= valid_d;
            multi_q  <= multi_d;
            strobe_q <= strobe_d;
        end
    end

    assign code   = code_q;
    assign valid  = valid_q;
    assign strobe = strobe_q;
    assign multi  = multi_q;

endmodule

// File: tb/tb_key8_encoder.sv
// tb_key8_encoder: directed self-checking bench for key8_encoder with
// DEBOUNCE_CYCLES=4 (press/release accepted after edge 7) and REPEAT_CYCLES=8.
// Inputs are driven and outputs sampled on the falling edge; "edge 1" is the
// first rising edge after a change.

module tb_key8_encoder;

    logic       clk;
    logic       rst;
    logic [7:0] keys_n;
    logic [2:0] code;
    logic       valid;
    logic       strobe;
    logic       multi;

    int errors;
    int checks;
    int n_strobe;

    key8_encoder #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_CYCLES   (8)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .keys_n (keys_n),
        .code   (code),
        .valid  (valid),
        .strobe (strobe),
        .multi  (multi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to the next falling edge and tally any strobe seen there.
    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            if (strobe === 1'b1) n_strobe++;
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        n_strobe = 0;

        // Reset with every key pressed.
        rst    = 1'b1;
        keys_n = 8'h00;
        tick(3);
        check("rst_code",   8'(code),   8'd0);
        check("rst_valid",  8'(valid),  8'd0);
        check("rst_strobe", 8'(strobe), 8'd0);
        check("rst_multi",  8'(multi),  8'd0);

        // Held-through-reset pattern becomes a new press 7 edges later.
        rst      = 1'b0;
        n_strobe = 0;
        tick(6);
        check("rst_early_strobes", 8'(n_strobe), 8'd0);
        tick(1);
        check("rst_strobe_e7", 8'(strobe), 8'd1);
        check("rst_valid_e7",  8'(valid),  8'd1);
        check("rst_code_e7",   8'(code),   8'd0);
        check("rst_multi_e7",  8'(multi),  8'd1);
        keys_n = 8'hFF;
        tick(7);
        check("rst_rel_valid", 8'(valid), 8'd0);
        check("rst_rel_multi", 8'(multi), 8'd0);

        // Clean press of key 5.
        keys_n   = 8'b11011111;
        n_strobe = 0;
        tick(6);
        check("clean_valid_e6",  8'(valid),    8'd0);
        check("clean_strobe_e6", 8'(n_strobe), 8'd0);
        tick(1);
        check("clean_strobe_e7", 8'(strobe), 8'd1);
        check("clean_valid_e7",  8'(valid),  8'd1);
        check("clean_code_e7",   8'(code),   8'd5);
        check("clean_multi_e7",  8'(multi),  8'd0);
        tick(1);
        check("clean_strobe_e8", 8'(strobe), 8'd0);

        // Clean release.
        keys_n = 8'hFF;
        tick(6);
        check("clean_rel_valid_e6", 8'(valid), 8'd1);
        tick(1);
        check("clean_rel_valid_e7", 8'(valid), 8'd0);
        check("clean_rel_code",     8'(code),  8'd5);
        tick(10);
        check("clean_strobe_total", 8'(n_strobe), 8'd1);

        // Bouncing key 2: toggle every 2 cycles for 20 cycles.
        n_strobe = 0;
        for (int i = 0; i < 10; i++) begin
            keys_n = (i % 2 == 0) ? 8'b11111011 : 8'hFF;
            tick(2);
        end
        check("bounce_no_strobe", 8'(n_strobe), 8'd0);
        check("bounce_no_valid",  8'(valid),    8'd0);
        keys_n = 8'b11111011;
        tick(6);
        check("bounce_hold_e6", 8'(n_strobe), 8'd0);
        tick(1);
        check("bounce_strobe_e7", 8'(strobe), 8'd1);
        check("bounce_code_e7",   8'(code),   8'd2);
        tick(3);
        check("bounce_one_strobe", 8'(n_strobe), 8'd1);
        keys_n = 8'hFF;
        tick(8);
        check("bounce_rel_valid", 8'(valid), 8'd0);

        // Chord of keys 0 and 7, then roll to key 7 alone.
        keys_n   = 8'b01111110;
        n_strobe = 0;
        tick(7);
        check("chord_strobe", 8'(strobe), 8'd1);
        check("chord_code",   8'(code),   8'd0);
        check("chord_multi",  8'(multi),  8'd1);
        keys_n = 8'b01111111;
        tick(5);
        check("chord_roll_code",  8'(code),     8'd0);
        check("chord_roll_multi", 8'(multi),    8'd1);
        check("chord_roll_count", 8'(n_strobe), 8'd1);

        // Release bounce: 3 released samples, 5 cycles of key 0, release.
        keys_n = 8'hFF;
        tick(3);
        check("relb_valid_a", 8'(valid), 8'd1);
        keys_n = 8'b11111110;
        tick(5);
        check("relb_valid_b", 8'(valid), 8'd1);
        keys_n = 8'hFF;
        tick(6);
        check("relb_valid_e6", 8'(valid), 8'd1);
        tick(1);
        check("relb_valid_e7", 8'(valid),    8'd0);
        check("relb_code",     8'(code),     8'd0);
        check("relb_count",    8'(n_strobe), 8'd1);

        // Long hold of key 3: auto-repeat when compiled in, silence otherwise.
        keys_n   = 8'b11110111;
        n_strobe = 0;
        tick(7);
        check("hold_strobe", 8'(strobe), 8'd1);
        check("hold_code",   8'(code),   8'd3);
        n_strobe = 0;
`ifdef KEY8_ENC_REPEAT_EN
        for (int k = 1; k <= 5; k++) begin
            tick(7);
            check("rep_gap", 8'(n_strobe), 8'(k - 1));
            tick(1);
            check("rep_strobe", 8'(strobe), 8'd1);
            check("rep_code",   8'(code),   8'd3);
        end
        check("rep_total", 8'(n_strobe), 8'd5);
`else
        tick(40);
        check("hold_no_repeat", 8'(n_strobe), 8'd0);
        check("hold_valid",     8'(valid),    8'd1);
`endif
        keys_n = 8'hFF;
        tick(8);
        check("hold_rel_valid", 8'(valid), 8'd0);
        check("hold_rel_code",  8'(code),  8'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
